// File: rtl/processor_pkg.sv
// Shared constants for the 5-stage MIPS pipeline: datapath widths, NOP encoding
// and the primary opcodes decoded downstream by dependency_Module.
package processor_pkg;

    localparam int unsigned INS_W   = 32;
    localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0000;
    localparam logic [31:0] PC_INC  = 32'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/ins_memory.sv
// Instruction memory: synchronous program-load write, asynchronous read.
// A same-cycle write and read of one index returns the old word.
module ins_memory
    import processor_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [INS_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [INS_W-1:0] rdata
);

    logic [INS_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program counter, local instruction memory and the IF/ID register,
// with reset > branch > flush > stall > normal update priority.
module instruction_fetch
    import processor_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          br_taken,
    input  logic [31:0]                   br_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [INS_W-1:0]              imem_wdata,
    output logic [INS_W-1:0]              ins,
    output logic [31:0]                   pc_out,
    output logic                          ins_valid,
    output logic [15:0]                   fetch_count
);

    localparam int unsigned AW      = $clog2(IMEM_DEPTH);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [31:0]      pc_q, pc_d;
    logic [INS_W-1:0] ins_q, ins_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic             ins_valid_q, ins_valid_d;
    logic [15:0]      fetch_count_q, fetch_count_d;
    logic [INS_W-1:0] imem_rdata;

    ins_memory #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_ins_memory (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc_q[AW+1:2]),
        .rdata (imem_rdata)
    );

    // Next-state selection; reset is applied in the register block.
    always_comb begin
        pc_d          = pc_q;
        ins_d         = ins_q;
        pc_out_d      = pc_out_q;
        ins_valid_d   = ins_valid_q;
        fetch_count_d = fetch_count_q;

        if (br_taken) begin
            pc_d        = br_target & 32'hFFFF_FFFC;
            ins_d       = NOP_INS;
            ins_valid_d = 1'b0;
        end else if (flush) begin
            ins_d       = NOP_INS;
            ins_valid_d = 1'b0;
            if (!stall) begin
                pc_d = pc_q + PC_INC;
            end
        end else if (!stall) begin
            ins_d       = imem_rdata;
            pc_out_d    = pc_q;
            ins_valid_d = 1'b1;
            pc_d        = pc_q + PC_INC;
            if (fetch_count_q != CNT_MAX) begin
                fetch_count_d = fetch_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ins_q         <= NOP_INS;
            pc_out_q      <= 32'h0;
            ins_valid_q   <= 1'b0;
            fetch_count_q <= 16'h0;
        end else begin
            pc_q          <= pc_d;
            ins_q         <= ins_d;
            pc_out_q      <= pc_out_d;
            ins_valid_q   <= ins_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign ins         = ins_q;
    assign pc_out      = pc_out_q;
    assign ins_valid   = ins_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, first fetch, stall, flush,
// branch, address wrap, read-before-write, mid-run reset and counter saturation.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] ins;
    logic [31:0] pc_out;
    logic        ins_valid;
    logic [15:0] fetch_count;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    logic [31:0] mem_m [64];
    logic [15:0] exp_cnt;

    instruction_fetch #(
        .IMEM_DEPTH (64),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .ins         (ins),
        .pc_out      (pc_out),
        .ins_valid   (ins_valid),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] exp_ins,
                               input logic [31:0] exp_pc, input logic exp_valid);
        check({tag, ".ins"}, ins, exp_ins);
        check({tag, ".pc_out"}, pc_out, exp_pc);
        check({tag, ".valid"}, 32'(ins_valid), 32'(exp_valid));
        check({tag, ".count"}, 32'(fetch_count), 32'(exp_cnt));
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        imem_we    = 1'b0;
        imem_waddr = 6'd0;
        imem_wdata = 32'h0;
        exp_cnt    = 16'd0;

        for (int i = 0; i < 64; i++) begin
            mem_m[i] = 32'h1000_0000 | 32'(i);
        end
        mem_m[0] = 32'h0022_1800;
        mem_m[1] = 32'h5081_0000;

        // Program load while held in reset.
        for (int i = 0; i < 64; i++) begin
            imem_we    = 1'b1;
            imem_waddr = 6'(i);
            imem_wdata = mem_m[i];
            step();
        end
        imem_we = 1'b0;
        step();
        check_fetch("reset", 32'h0, 32'h0, 1'b0);

        // First fetches after reset release.
        reset = 1'b0;
        step();
        exp_cnt = 16'd1;
        check_fetch("first0", 32'h0022_1800, 32'h0, 1'b1);
        step();
        exp_cnt = 16'd2;
        check_fetch("first1", 32'h5081_0000, 32'h4, 1'b1);

        // Two-cycle stall at pc=8.
        stall = 1'b1;
        step();
        check_fetch("stall0", 32'h5081_0000, 32'h4, 1'b1);
        step();
        check_fetch("stall1", 32'h5081_0000, 32'h4, 1'b1);
        stall = 1'b0;
        step();
        exp_cnt = 16'd3;
        check_fetch("unstall", mem_m[2], 32'h8, 1'b1);

        // Flush at pc=12: bubble, pc still advances.
        flush = 1'b1;
        step();
        check_fetch("flush", 32'h0, 32'h8, 1'b0);
        flush = 1'b0;
        step();
        exp_cnt = 16'd4;
        check_fetch("postflush", mem_m[4], 32'h10, 1'b1);

        // Branch while stalled; low target bits ignored.
        br_taken  = 1'b1;
        br_target = 32'h0000_0013;
        stall     = 1'b1;
        step();
        check_fetch("br_bubble", 32'h0, 32'h10, 1'b0);
        br_taken = 1'b0;
        stall    = 1'b0;
        step();
        exp_cnt = 16'd5;
        check_fetch("br_target", mem_m[4], 32'h10, 1'b1);

        // Index wrap: byte 0x100 maps to word 0.
        br_taken  = 1'b1;
        br_target = 32'h0000_0100;
        step();
        br_taken = 1'b0;
        step();
        exp_cnt = 16'd6;
        check_fetch("wrap_idx", mem_m[0], 32'h100, 1'b1);

        // PC wrap across 2^32.
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFC;
        step();
        br_taken = 1'b0;
        step();
        exp_cnt = 16'd7;
        check_fetch("wrap_top", mem_m[63], 32'hFFFF_FFFC, 1'b1);
        step();
        exp_cnt = 16'd8;
        check_fetch("wrap_zero", mem_m[0], 32'h0, 1'b1);

        // Write and fetch of word 1 in the same cycle returns the old word.
        imem_we    = 1'b1;
        imem_waddr = 6'd1;
        imem_wdata = 32'hDEAD_BEEF;
        step();
        imem_we = 1'b0;
        exp_cnt = 16'd9;
        check_fetch("rbw_old", 32'h5081_0000, 32'h4, 1'b1);
        mem_m[1] = 32'hDEAD_BEEF;
        br_taken  = 1'b1;
        br_target = 32'h0000_0004;
        step();
        br_taken = 1'b0;
        step();
        exp_cnt = 16'd10;
        check_fetch("rbw_new", 32'hDEAD_BEEF, 32'h4, 1'b1);

        // Flush with stall holds pc (now 8).
        flush = 1'b1;
        stall = 1'b1;
        step();
        check_fetch("flush_stall", 32'h0, 32'h4, 1'b0);
        flush = 1'b0;
        stall = 1'b0;
        step();
        exp_cnt = 16'd11;
        check_fetch("after_fs", mem_m[2], 32'h8, 1'b1);

        // Reset during a branch wins.
        reset     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h0000_0040;
        step();
        exp_cnt = 16'd0;
        check_fetch("reset_br", 32'h0, 32'h0, 1'b0);
        reset    = 1'b0;
        br_taken = 1'b0;
        step();
        exp_cnt = 16'd1;
        check_fetch("reset_pc", mem_m[0], 32'h0, 1'b1);

        // Drive the counter to 16'hFFFE, then confirm saturation.
        for (int i = 0; i < 65533; i++) begin
            step();
        end
        check("cnt_fffe", 32'(fetch_count), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            check("cnt_sat", 32'(fetch_count), 32'h0000_FFFF);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of `dependency_Module` and driving its `ins` input. It holds the program counter, reads a local instruction memory, and registers the fetched word into the IF/ID register. The block honours stall, flush and branch-redirect requests from downstream, and it counts issued instructions.

## Interface
Parameters:
- `IMEM_DEPTH`, default 64: instruction memory depth in 32-bit words; must be a power of 2.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold PC and IF/ID contents.
- `flush`  in  1  squash the IF/ID contents (insert NOP).
- `br_taken`  in  1  redirect fetch to `br_target`.
- `br_target`  in  32  redirect byte address; bits [1:0] are ignored (treated as 0).
- `imem_we`  in  1  program-load write enable.
- `imem_waddr`  in  log2(IMEM_DEPTH)  program-load word index.
- `imem_wdata`  in  32  program-load word.
- `ins`  out  32  registered instruction, goes to `dependency_Module.ins`.
- `pc_out`  out  32  byte address of the word currently in `ins`.
- `ins_valid`  out  1  `ins` holds a real fetched instruction (not a NOP bubble).
- `fetch_count`  out  16  number of instructions issued; saturates.

## Operation
- Internal `pc` register (32 bit).
- Memory read is combinational at word index `pc[log2(IMEM_DEPTH)+1:2]`. Higher PC bits are ignored, so addresses wrap modulo `IMEM_DEPTH*4`.
- Update priority on each rising edge, highest first: reset > br_taken > flush > stall > normal.
  - **reset:** `pc`=RESET_PC, `ins`=NOP (32'h0), `pc_out`=0, `ins_valid`=0, `fetch_count`=0. Memory contents are not cleared.
  - **br_taken:** `pc`={br_target[31:2],2'b00}; `ins`=NOP; `ins_valid`=0; `pc_out` holds its value. This applies regardless of `stall` and `flush`.
  - **flush (no branch):** `ins`=NOP and `ins_valid`=0. `pc` advances by 4 unless `stall` is high, in which case `pc` holds.
  - **stall (no branch, no flush):** `pc`, `ins`, `pc_out`, `ins_valid` and `fetch_count` all hold.
  - **normal:** `ins`=imem[pc], `pc_out`=pc, `ins_valid`=1, `pc`=pc+4.
- PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- `fetch_count` increments on each edge where the normal path loads a word. It saturates at 16'hFFFF.
- Memory write (`imem_we`) happens on the edge, independent of stall, flush or reset.
- If a write and a read hit the same index in the same cycle, the fetch gets the old data (read-before-write).

## Timing
- Fetch latency is 1 cycle: a word at `pc` appears on `ins` after the next rising edge.
- After reset deasserts: the first edge loads imem[RESET_PC>>2] with `ins_valid`=1.
- Branch penalty is 1 bubble. The edge that samples `br_taken` outputs a NOP; the following edge outputs imem[target].
- A stall held for N cycles freezes all outputs for exactly N edges; there is no replay or skip on release.
- Reset asserted mid-stream overrides everything on that same edge; there is no partial state.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `processor_pkg`:
  - `INS_W`=32
  - `NOP_INS`=32'h0000_0000
  - `PC_INC`=4
  - the opcode constants also used by `dependency_Module`
- Sub-module `ins_memory`: `IMEM_DEPTH`x32 array with synchronous write and asynchronous read. It has no reset. It is instantiated once.
- The top level holds the PC register, the IF/ID register, the priority logic and the counter.

## Test plan
- **Reset/first fetch:** load imem[0]=32'h0022_1800 and imem[1]=32'h5081_0000, then release reset. Required: `ins`=32'h0022_1800 with `pc_out`=0 and `ins_valid`=1, then 32'h5081_0000 with `pc_out`=4; `fetch_count`=2.
- **Stall:** assert `stall` for 2 cycles at `pc`=8. Required: `ins`, `pc_out` and `fetch_count` are unchanged for 2 edges; the next fetch has `pc_out`=8.
- **Branch:** set `br_taken`=1 with `br_target`=32'h0000_0013 while `stall`=1. Required: NOP with `ins_valid`=0 on that edge, then `ins`=imem[4] with `pc_out`=32'h10.
- **Flush only:** assert `flush` for 1 cycle at `pc`=12. Required: a NOP bubble; `pc` still advances; the next `ins` has `pc_out`=16 and `fetch_count` does not increment for the bubble.
- **Wrap:** with `IMEM_DEPTH`=64, set `br_target`=32'h100. Required: fetch returns imem[0]. Also set `br_target`=32'hFFFF_FFFC. Required: the following fetch has `pc_out`=0.
- **Reset mid-run and saturation:**
  - Assert `reset` during a branch. Required: `ins`=NOP, `fetch_count`=0, `pc`=RESET_PC.
  - Force `fetch_count` to 16'hFFFE and issue 3 fetches. Required: it stays at 16'hFFFF.
